// File: rtl/logic_gate_arbiter_pkg.sv
// Shared types and constants for the two-port gate arbiter.
// Opcodes, FSM encoding and the round-robin grant helper.
package logic_gate_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_NOT = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // bit0 = requester 0, bit1 = requester 1; one-hot or zero
  function automatic logic [1:0] rr_grant(
    input logic v0,
    input logic v1,
    input logic last
  );
    logic [1:0] g;
    g = 2'b00;
    if (v0 && v1) begin
      g = last ? 2'b01 : 2'b10;
    end else if (v0) begin
      g = 2'b01;
    end else if (v1) begin
      g = 2'b10;
    end
    return g;
  endfunction

endpackage

// File: rtl/logic_gate_arbiter_if.sv
// Request/response handshake bundle for the gate arbiter.
// master = requesters + consumer side, slave = arbiter side.
interface logic_gate_arbiter_if #(
  parameter int WIDTH = 4
);

  logic             iReq0Valid;
  logic             oReq0Ready;
  logic [1:0]       iReq0Op;
  logic [WIDTH-1:0] iReq0A;
  logic [WIDTH-1:0] iReq0B;

  logic             iReq1Valid;
  logic             oReq1Ready;
  logic [1:0]       iReq1Op;
  logic [WIDTH-1:0] iReq1A;
  logic [WIDTH-1:0] iReq1B;

  logic             oRspValid;
  logic             iRspReady;
  logic             oRspId;
  logic [WIDTH-1:0] oRspData;
  logic             oRspErr;
  logic [7:0]       oDoneCnt;

  modport master (
    output iReq0Valid, iReq0Op, iReq0A, iReq0B,
    input  oReq0Ready,
    output iReq1Valid, iReq1Op, iReq1A, iReq1B,
    input  oReq1Ready,
    input  oRspValid, oRspId, oRspData, oRspErr,
    output iRspReady,
    input  oDoneCnt
  );

  modport slave (
    input  iReq0Valid, iReq0Op, iReq0A, iReq0B,
    output oReq0Ready,
    input  iReq1Valid, iReq1Op, iReq1A, iReq1B,
    output oReq1Ready,
    output oRspValid, oRspId, oRspData, oRspErr,
    input  iRspReady,
    output oDoneCnt
  );

endinterface

// File: rtl/logic_gate_arbiter_gates_vec.sv
// Bitwise gate primitives shared by both requesters.
// Purely combinational; the arbiter picks one output.
module logic_gates_vec #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic [WIDTH-1:0] oAnd,
  output logic [WIDTH-1:0] oOr,
  output logic [WIDTH-1:0] oNot
);

  assign oAnd = iA & iB;
  assign oOr  = iA | iB;
  assign oNot = ~iA;

endmodule

// File: rtl/logic_gate_arbiter.sv
// Round-robin arbiter sharing one gate unit between two
// requesters; IDLE -> EXEC -> RESP, registered response.
module logic_gate_arbiter
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic                 iClk,
  input logic                 iRst,
  logic_gate_arbiter_if.slave bus
);

  state_e           state_q;
  logic             last_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;

  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic [7:0]       done_cnt_q;

  logic [1:0]       gnt_d;
  logic             idle;
  logic [WIDTH-1:0] g_and;
  logic [WIDTH-1:0] g_or;
  logic [WIDTH-1:0] g_not;
  logic [WIDTH-1:0] res_d;
  logic             err_d;

  assign idle  = (state_q == ST_IDLE);
  assign gnt_d = idle ? rr_grant(bus.iReq0Valid,
                                 bus.iReq1Valid,
                                 last_q)
                      : 2'b00;

  assign bus.oReq0Ready = gnt_d[0];
  assign bus.oReq1Ready = gnt_d[1];

  assign bus.oRspValid = rsp_valid_q;
  assign bus.oRspId    = rsp_id_q;
  assign bus.oRspData  = rsp_data_q;
  assign bus.oRspErr   = rsp_err_q;
  assign bus.oDoneCnt  = done_cnt_q;

  logic_gates_vec #(
    .WIDTH(WIDTH)
  ) u_gates (
    .iA  (a_q),
    .iB  (b_q),
    .oAnd(g_and),
    .oOr (g_or),
    .oNot(g_not)
  );

  // select the gate output for the latched opcode
  always_comb begin
    res_d = '0;
    err_d = 1'b0;
    unique case (1'b1)
      (op_q == OP_AND): res_d = g_and;
      (op_q == OP_OR):  res_d = g_or;
      (op_q == OP_NOT): res_d = g_not;
      (op_q == OP_RSV): err_d = 1'b1;
    endcase
  end

  // transaction sequencer with registered response outputs
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      op_q        <= OP_AND;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      done_cnt_q  <= 8'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (gnt_d[1]) begin
            state_q <= ST_EXEC;
            op_q    <= bus.iReq1Op;
            a_q     <= bus.iReq1A;
            b_q     <= bus.iReq1B;
            id_q    <= 1'b1;
            last_q  <= 1'b1;
          end else if (gnt_d[0]) begin
            state_q <= ST_EXEC;
            op_q    <= bus.iReq0Op;
            a_q     <= bus.iReq0A;
            b_q     <= bus.iReq0B;
            id_q    <= 1'b0;
            last_q  <= 1'b0;
          end
        end
        ST_EXEC: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= res_d;
          rsp_err_q   <= err_d;
          rsp_id_q    <= id_q;
        end
        ST_RESP: begin
          if (bus.iRspReady) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            done_cnt_q  <= done_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_gate_arbiter.sv
// Directed bench for logic_gate_arbiter: vector table of
// single transactions plus multi-cycle corner sequences.
module tb_logic_gate_arbiter;

  localparam int W = 4;

  logic clk;
  logic rst;

  logic_gate_arbiter_if #(.WIDTH(W)) bus ();

  logic_gate_arbiter #(
    .WIDTH(W)
  ) dut (
    .iClk(clk),
    .iRst(rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic         id;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] data;
    logic         err;
  } vec_t;

  vec_t tbl[10];
  int   n_cmp;
  int   n_err;
  int   exp_cnt;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input logic id,
                         input logic v,
                         input logic [1:0] op,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b);
    if (id) begin
      bus.iReq1Valid = v;
      bus.iReq1Op    = op;
      bus.iReq1A     = a;
      bus.iReq1B     = b;
    end else begin
      bus.iReq0Valid = v;
      bus.iReq0Op    = op;
      bus.iReq0A     = a;
      bus.iReq0B     = b;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.iReq0Valid = 1'b0;
    bus.iReq1Valid = 1'b0;
    bus.iRspReady  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic txn(input vec_t v);
    logic got;
    logic rdy;
    @(negedge clk);
    set_req(v.id, 1'b1, v.op, v.a, v.b);
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      #1;
      rdy = v.id ? bus.oReq1Ready : bus.oReq0Ready;
      if (rdy) got = 1'b1;
      else @(negedge clk);
    end
    chk("txn_ready", {31'd0, got}, 32'd1);
    if (!got) begin
      set_req(v.id, 1'b0, v.op, v.a, v.b);
      return;
    end
    @(negedge clk);
    set_req(v.id, 1'b0, v.op, v.a, v.b);
    chk("exec_valid", {31'd0, bus.oRspValid}, 32'd0);
    @(negedge clk);
    chk("rsp_valid", {31'd0, bus.oRspValid}, 32'd1);
    chk("rsp_data", {28'd0, bus.oRspData}, {28'd0, v.data});
    chk("rsp_id", {31'd0, bus.oRspId}, {31'd0, v.id});
    chk("rsp_err", {31'd0, bus.oRspErr}, {31'd0, v.err});
    bus.iRspReady = 1'b1;
    @(negedge clk);
    bus.iRspReady = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
    chk("done_valid", {31'd0, bus.oRspValid}, 32'd0);
    chk("done_cnt", {24'd0, bus.oDoneCnt}, exp_cnt);
  endtask

  initial begin
    int nrsp;
    int ngnt;
    int hs;
    n_cmp = 0;
    n_err = 0;
    exp_cnt = 0;
    rst = 1'b1;
    bus.iReq0Valid = 1'b0;
    bus.iReq0Op = 2'b00;
    bus.iReq0A = '0;
    bus.iReq0B = '0;
    bus.iReq1Valid = 1'b0;
    bus.iReq1Op = 2'b00;
    bus.iReq1A = '0;
    bus.iReq1B = '0;
    bus.iRspReady = 1'b0;

    tbl[0] = '{1'b0, 2'b00, 4'hC, 4'hA, 4'h8, 1'b0};
    tbl[1] = '{1'b1, 2'b00, 4'hF, 4'h5, 4'h5, 1'b0};
    tbl[2] = '{1'b0, 2'b01, 4'h3, 4'h4, 4'h7, 1'b0};
    tbl[3] = '{1'b1, 2'b01, 4'h8, 4'h1, 4'h9, 1'b0};
    tbl[4] = '{1'b0, 2'b10, 4'h5, 4'hF, 4'hA, 1'b0};
    tbl[5] = '{1'b1, 2'b10, 4'h0, 4'hF, 4'hF, 1'b0};
    tbl[6] = '{1'b1, 2'b11, 4'hF, 4'hF, 4'h0, 1'b1};
    tbl[7] = '{1'b0, 2'b00, 4'hF, 4'hF, 4'hF, 1'b0};
    tbl[8] = '{1'b0, 2'b11, 4'h5, 4'h5, 4'h0, 1'b1};
    tbl[9] = '{1'b1, 2'b10, 4'hA, 4'h0, 4'h5, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", {31'd0, bus.oRspValid}, 32'd0);
    chk("rst_data", {28'd0, bus.oRspData}, 32'd0);
    chk("rst_id", {31'd0, bus.oRspId}, 32'd0);
    chk("rst_err", {31'd0, bus.oRspErr}, 32'd0);
    chk("rst_cnt", {24'd0, bus.oDoneCnt}, 32'd0);
    chk("rst_rdy0", {31'd0, bus.oReq0Ready}, 32'd0);

    for (int i = 0; i < 10; i++) txn(tbl[i]);

    // both requesters valid continuously: grants alternate
    do_reset();
    @(negedge clk);
    set_req(1'b0, 1'b1, 2'b01, 4'h3, 4'h4);
    set_req(1'b1, 1'b1, 2'b10, 4'h5, 4'h0);
    bus.iRspReady = 1'b1;
    nrsp = 0;
    ngnt = 0;
    for (int c = 0; c < 40 && nrsp < 4; c++) begin
      #1;
      if (bus.oReq0Ready || bus.oReq1Ready) begin
        chk("alt_both_rdy",
            {31'd0, bus.oReq0Ready & bus.oReq1Ready}, 32'd0);
        chk("alt_grant", {31'd0, bus.oReq1Ready}, ngnt % 2);
        ngnt++;
      end
      if (bus.oRspValid) begin
        chk("alt_data", {28'd0, bus.oRspData},
            (nrsp % 2) ? 32'hA : 32'h7);
        chk("alt_id", {31'd0, bus.oRspId}, nrsp % 2);
        nrsp++;
        exp_cnt++;
      end
      @(negedge clk);
    end
    if (nrsp < 4) begin
      chk("alt_timeout", nrsp, 4);
    end
    set_req(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
    set_req(1'b1, 1'b0, 2'b00, 4'h0, 4'h0);
    bus.iRspReady = 1'b0;
    #1;
    chk("alt_cnt", {24'd0, bus.oDoneCnt}, exp_cnt);

    // response stall with req0 waiting
    do_reset();
    @(negedge clk);
    set_req(1'b0, 1'b1, 2'b00, 4'hC, 4'hA);
    #1;
    chk("stall_rdy_a", {31'd0, bus.oReq0Ready}, 32'd1);
    @(negedge clk);
    set_req(1'b0, 1'b1, 2'b01, 4'h3, 4'h4);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", {31'd0, bus.oRspValid}, 32'd1);
      chk("stall_data", {28'd0, bus.oRspData}, 32'h8);
      chk("stall_rdy0", {31'd0, bus.oReq0Ready}, 32'd0);
      @(negedge clk);
    end
    chk("stall_hold", {28'd0, bus.oRspData}, 32'h8);
    bus.iRspReady = 1'b1;
    @(negedge clk);
    bus.iRspReady = 1'b0;
    #1;
    chk("stall_rel_valid", {31'd0, bus.oRspValid}, 32'd0);
    chk("stall_rel_rdy0", {31'd0, bus.oReq0Ready}, 32'd1);
    chk("stall_rel_cnt", {24'd0, bus.oDoneCnt}, 32'd1);
    @(negedge clk);
    set_req(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
    @(negedge clk);
    chk("stall2_valid", {31'd0, bus.oRspValid}, 32'd1);
    chk("stall2_data", {28'd0, bus.oRspData}, 32'h7);
    chk("stall2_id", {31'd0, bus.oRspId}, 32'd0);
    bus.iRspReady = 1'b1;
    @(negedge clk);
    bus.iRspReady = 1'b0;

    // reset during EXEC discards the transaction
    do_reset();
    @(negedge clk);
    set_req(1'b1, 1'b1, 2'b00, 4'hF, 4'hF);
    #1;
    chk("rx_rdy1", {31'd0, bus.oReq1Ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    set_req(1'b0, 1'b1, 2'b01, 4'h1, 4'h2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rx_valid", {31'd0, bus.oRspValid}, 32'd0);
    chk("rx_rdy0", {31'd0, bus.oReq0Ready}, 32'd1);
    chk("rx_rdy1_tie", {31'd0, bus.oReq1Ready}, 32'd0);
    chk("rx_cnt", {24'd0, bus.oDoneCnt}, 32'd0);
    set_req(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
    set_req(1'b1, 1'b0, 2'b00, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rx_no_rsp", {31'd0, bus.oRspValid}, 32'd0);
    end

    // done counter wrap at 256 and 257 completions
    do_reset();
    @(negedge clk);
    set_req(1'b0, 1'b1, 2'b00, 4'hF, 4'hF);
    bus.iRspReady = 1'b1;
    hs = 0;
    for (int c = 0; c < 1200 && hs < 257; c++) begin
      @(negedge clk);
      if (bus.oRspValid) begin
        hs++;
        if (hs == 256 || hs == 257) begin
          @(negedge clk);
          chk(hs == 256 ? "wrap_256" : "wrap_257",
              {24'd0, bus.oDoneCnt}, hs % 256);
        end
      end
    end
    if (hs < 257) begin
      chk("wrap_timeout", hs, 257);
    end
    set_req(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
    bus.iRspReady = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
